// File: rtl/rapids_pkg.sv
// Shared fetch-path types, widths and address helpers.
package rapids_pkg;

  localparam int unsigned INSTR_W = 32;
  localparam int unsigned ADDR_W  = 32;
  localparam logic [INSTR_W-1:0] NOP_WORD = 32'h0;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BUSY    = 2'd1,
    DISCARD = 2'd2
  } fetch_state_t;

  // One prefetch slot: returned word, its address and a fault marker.
  typedef struct packed {
    logic [INSTR_W-1:0] data;
    logic [ADDR_W-1:0]  addr;
    logic               segv;
  } fetch_entry_t;

  // Word aligned and inside [base, limit); the single subtraction also rejects a < base.
  function automatic logic fetch_ok(input logic [ADDR_W-1:0] a,
                                    input logic [ADDR_W-1:0] base,
                                    input logic [ADDR_W-1:0] limit);
    return (a[1:0] == 2'b00) && ((a - base) < (limit - base));
  endfunction

endpackage

// File: rtl/instr_fetch_if.sv
// Instruction-supply and instruction-memory signals of the fetch front end.
interface instr_fetch_if;
  import rapids_pkg::*;

  logic               pc_inc;
  logic               redirect;
  logic [ADDR_W-1:0]  redirect_pc;
  logic [INSTR_W-1:0] instruction;
  logic               wait_instr;
  logic               instr_segv;
  logic [ADDR_W-1:0]  pc;
  logic               mem_req;
  logic [ADDR_W-1:0]  mem_addr;
  logic               mem_ack;
  logic [INSTR_W-1:0] mem_rdata;
  logic               mem_fault;

  // Fetch unit side.
  modport master (
    input  pc_inc, redirect, redirect_pc, mem_ack, mem_rdata, mem_fault,
    output instruction, wait_instr, instr_segv, pc, mem_req, mem_addr
  );

  // Consumer / memory side.
  modport slave (
    output pc_inc, redirect, redirect_pc, mem_ack, mem_rdata, mem_fault,
    input  instruction, wait_instr, instr_segv, pc, mem_req, mem_addr
  );
endinterface

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO with flush; flush wins over push and pop.
module fetch_fifo #(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned WIDTH = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic [WIDTH-1:0]       wr_data,
  input  logic                   pop,
  input  logic                   flush,
  output logic [WIDTH-1:0]       rd_data,
  output logic [$clog2(DEPTH):0] count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             do_push, do_pop;

  // Pointer and occupancy update; a pop frees a slot for a same-cycle push.
  always_comb begin
    do_pop   = pop && (count_q != '0);
    do_push  = push && ((count_q != CW'(DEPTH)) || do_pop);
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      count_d = count_q + CW'(do_push) - CW'(do_pop);
    end
  end

  // Pointer/count state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage; contents are only observed through a nonzero count.
  always_ff @(posedge clk) begin
    if (do_push && !flush) mem_q[wr_ptr_q] <= wr_data;
  end

  assign rd_data = mem_q[rd_ptr_q];
  assign count   = count_q;

endmodule

// File: rtl/instr_fetch.sv
// Instruction-fetch front end: fetch PC, single-outstanding memory reads, prefetch buffer.
module instr_fetch
  import rapids_pkg::*;
#(
  parameter int unsigned       DEPTH      = 2,
  parameter logic [ADDR_W-1:0] RESET_PC   = 32'h0000_0000,
  parameter logic [ADDR_W-1:0] TEXT_BASE  = 32'h0000_0000,
  parameter logic [ADDR_W-1:0] TEXT_LIMIT = 32'h0001_0000
) (
  input logic          clk,
  input logic          rst,
  instr_fetch_if.master bus
);

  localparam int unsigned CW = $clog2(DEPTH) + 1;
  localparam int unsigned EW = $bits(fetch_entry_t);

  fetch_state_t      state_q, state_d;
  logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic              mem_req_q, mem_req_d;
  logic              halted_q, halted_d;

  logic              push, pop, head_valid;
  fetch_entry_t      push_entry, head;
  logic [EW-1:0]     head_bits;
  logic [CW-1:0]     count_w;

  fetch_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (EW)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push    (push),
    .wr_data (push_entry),
    .pop     (pop),
    .flush   (bus.redirect),
    .rd_data (head_bits),
    .count   (count_w)
  );

  assign head       = fetch_entry_t'(head_bits);
  assign head_valid = (count_w != '0);

  // Head presentation; an empty buffer shows the address being fetched.
  assign bus.wait_instr  = !head_valid;
  assign bus.instr_segv  = head_valid && head.segv;
  assign bus.instruction = head_valid ? head.data : NOP_WORD;
  assign bus.pc          = head_valid ? head.addr : fetch_pc_q;
  assign bus.mem_req     = mem_req_q;
  assign bus.mem_addr    = mem_addr_q;

  // A faulting head is sticky; only a redirect removes it.
  assign pop = bus.pc_inc && head_valid && !head.segv && !bus.redirect;

  // Fetch sequencing: issue, collect, fault handling and redirect.
  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    mem_addr_d = mem_addr_q;
    mem_req_d  = mem_req_q;
    halted_d   = halted_q;
    push       = 1'b0;
    push_entry = '0;

    if (bus.redirect) begin
      fetch_pc_d = bus.redirect_pc;
      halted_d   = 1'b0;
      if ((state_q == BUSY || state_q == DISCARD) && !bus.mem_ack) begin
        state_d = DISCARD;
      end else begin
        state_d   = IDLE;
        mem_req_d = 1'b0;
      end
    end else begin
      unique case (state_q)
        IDLE: begin
          if ((count_w < CW'(DEPTH)) && !halted_q) begin
            if (fetch_ok(fetch_pc_q, TEXT_BASE, TEXT_LIMIT)) begin
              state_d    = BUSY;
              mem_req_d  = 1'b1;
              mem_addr_d = fetch_pc_q;
            end else begin
              push       = 1'b1;
              push_entry = '{data: NOP_WORD, addr: fetch_pc_q, segv: 1'b1};
              halted_d   = 1'b1;
            end
          end
        end
        BUSY: begin
          if (bus.mem_ack) begin
            push       = 1'b1;
            push_entry = '{data: bus.mem_rdata, addr: fetch_pc_q, segv: bus.mem_fault};
            fetch_pc_d = fetch_pc_q + ADDR_W'(4);
            halted_d   = bus.mem_fault;
            state_d    = IDLE;
            mem_req_d  = 1'b0;
          end
        end
        DISCARD: begin
          if (bus.mem_ack) begin
            state_d   = IDLE;
            mem_req_d = 1'b0;
          end
        end
        default: begin
          state_d   = IDLE;
          mem_req_d = 1'b0;
        end
      endcase
    end
  end

  // Fetch control state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      fetch_pc_q <= RESET_PC;
      mem_addr_q <= RESET_PC;
      mem_req_q  <= 1'b0;
      halted_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      mem_addr_q <= mem_addr_d;
      mem_req_q  <= mem_req_d;
      halted_q   <= halted_d;
    end
  end

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: directed scenarios, then a randomized run against a stream model.
module tb_instr_fetch;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  instr_fetch_if bus ();

  instr_fetch #(
    .DEPTH      (2),
    .RESET_PC   (32'h0000_0000),
    .TEXT_BASE  (32'h0000_0000),
    .TEXT_LIMIT (32'h0001_0000)
  ) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int pass_cnt = 0;
  int total_cnt = 0;
  int fail_cnt = 0;
  int cur_lat = 0;
  int req_age = 0;
  int fault_mode = 0;
  bit rand_lat = 0;
  bit prev_req = 0;
  bit prev_ack = 0;
  logic [31:0] prev_addr = '0;

  function automatic logic [31:0] word_of(input logic [31:0] a);
    return a ^ 32'hA5A5_0000;
  endfunction

  function automatic bit legal(input logic [31:0] a);
    return (a[1:0] == 2'b00) && (a < 32'h0001_0000);
  endfunction

  function automatic bit faulty(input logic [31:0] a);
    if (fault_mode == 1) return a == 32'h4;
    if (fault_mode == 2) return a[7:2] == 6'h2B;
    return 1'b0;
  endfunction

  function automatic logic [31:0] pick_target();
    logic [31:0] t;
    case ($urandom_range(0, 4))
      0, 1:    t = {20'h0, $urandom_range(0, 1023), 2'b00};
      2:       t = 32'h0000_FFE0 + 32'($urandom_range(0, 7) * 4);
      3:       t = {20'h0, $urandom_range(0, 1023), 2'b00} | 32'($urandom_range(1, 3));
      default: t = $urandom_range(0, 1) ? 32'hFFFF_FFFC : $urandom;
    endcase
    return t;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) begin
      pass_cnt++;
    end else begin
      fail_cnt++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_reset_vals();
    chk("rst_mem_req", bus.mem_req, 32'd0);
    chk("rst_mem_addr", bus.mem_addr, 32'h0);
    chk("rst_wait", bus.wait_instr, 32'd1);
    chk("rst_segv", bus.instr_segv, 32'd0);
    chk("rst_instr", bus.instruction, 32'h0);
    chk("rst_pc", bus.pc, 32'h0);
  endtask

  // Memory responder: answers the outstanding request after cur_lat cycles.
  task automatic mem_drive();
    if (rst || !bus.mem_req) begin
      bus.mem_ack = 1'b0;
      bus.mem_fault = 1'b0;
      req_age = 0;
    end else begin
      if (req_age == 0 && rand_lat) cur_lat = $urandom_range(0, 3);
      if (req_age >= cur_lat) begin
        bus.mem_ack = 1'b1;
        bus.mem_rdata = word_of(bus.mem_addr);
        bus.mem_fault = faulty(bus.mem_addr);
        req_age = 0;
      end else begin
        bus.mem_ack = 1'b0;
        bus.mem_fault = 1'b0;
        bus.mem_rdata = $urandom;
        req_age++;
      end
    end
  endtask

  // One cycle: sample at the falling edge, check request stability, drive memory.
  task automatic tick();
    @(negedge clk);
    if (prev_req && !prev_ack) begin
      chk("req_hold", bus.mem_req, 32'd1);
      chk("addr_hold", bus.mem_addr, prev_addr);
    end
    mem_drive();
    prev_req = bus.mem_req;
    prev_addr = bus.mem_addr;
    prev_ack = bus.mem_ack;
  endtask

  task automatic do_reset(input bit check);
    rst = 1'b1;
    bus.pc_inc = 1'b0;
    bus.redirect = 1'b0;
    bus.redirect_pc = '0;
    bus.mem_ack = 1'b0;
    bus.mem_rdata = '0;
    bus.mem_fault = 1'b0;
    prev_req = 0;
    prev_ack = 0;
    req_age = 0;
    @(negedge clk);
    if (check) check_reset_vals();
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    bit found, got, saw_low, any_req, exp_segv;
    logic [31:0] new_addr, exp_pc;
    int wait_run;

    // Reset values, then zero-wait fetch with pc_inc held high.
    do_reset(1);
    cur_lat = 0;
    fault_mode = 0;
    bus.pc_inc = 1'b1;
    tick();
    chk("b_req0", bus.mem_req, 32'd1);
    chk("b_addr0", bus.mem_addr, 32'h0);
    chk("b_wait0", bus.wait_instr, 32'd1);
    chk("ignored_pop_count", 32'(u_dut.count_w), 32'd0);
    tick();
    chk("b_vis0", bus.wait_instr, 32'd0);
    chk("b_instr0", bus.instruction, 32'hA5A5_0000);
    chk("b_pc0", bus.pc, 32'h0);
    tick();
    chk("b_wait1", bus.wait_instr, 32'd1);
    chk("b_addr1", bus.mem_addr, 32'h4);
    tick();
    chk("b_instr1", bus.instruction, 32'hA5A5_0004);
    chk("b_pc1", bus.pc, 32'h4);
    tick();
    chk("b_addr2", bus.mem_addr, 32'h8);
    chk("b_wait2", bus.wait_instr, 32'd1);

    // Redirect one cycle after the 0x8 request on a slow memory.
    do_reset(0);
    cur_lat = 3;
    bus.pc_inc = 1'b1;
    found = 0;
    for (int i = 0; i < 60 && !found; i++) begin
      tick();
      if (bus.mem_req && bus.mem_addr == 32'h8) found = 1;
    end
    chk("rd_req8_seen", 32'(found), 32'd1);
    bus.redirect = 1'b1;
    bus.redirect_pc = 32'h100;
    tick();
    bus.redirect = 1'b0;
    got = 0;
    saw_low = 0;
    new_addr = 32'hDEAD_BEEF;
    for (int i = 0; i < 40 && !got; i++) begin
      if (!bus.mem_req) saw_low = 1;
      else if (saw_low && new_addr == 32'hDEAD_BEEF) new_addr = bus.mem_addr;
      if (!bus.wait_instr) got = 1;
      else tick();
    end
    chk("rd_got", 32'(got), 32'd1);
    chk("rd_pc", bus.pc, 32'h100);
    chk("rd_instr", bus.instruction, 32'hA5A5_0100);
    chk("rd_next_addr", new_addr, 32'h100);

    // Bus fault on 0x4.
    do_reset(0);
    cur_lat = 0;
    fault_mode = 1;
    bus.pc_inc = 1'b1;
    tick();
    tick();
    chk("bf_pc0", bus.pc, 32'h0);
    chk("bf_instr0", bus.instruction, 32'hA5A5_0000);
    chk("bf_segv0", bus.instr_segv, 32'd0);
    tick();
    tick();
    chk("bf_pc4", bus.pc, 32'h4);
    chk("bf_segv4", bus.instr_segv, 32'd1);
    chk("bf_wait4", bus.wait_instr, 32'd0);
    chk("bf_data4", bus.instruction, 32'hA5A5_0004);
    any_req = 0;
    repeat (5) begin
      tick();
      if (bus.mem_req) any_req = 1;
    end
    chk("bf_no_req", 32'(any_req), 32'd0);
    chk("bf_segv_sticky", bus.instr_segv, 32'd1);

    // Redirect to TEXT_LIMIT: immediate fault entry, no request.
    fault_mode = 0;
    bus.pc_inc = 1'b0;
    bus.redirect = 1'b1;
    bus.redirect_pc = 32'h0001_0000;
    tick();
    bus.redirect = 1'b0;
    chk("oor_req_a", bus.mem_req, 32'd0);
    chk("oor_wait_a", bus.wait_instr, 32'd1);
    chk("oor_pc_a", bus.pc, 32'h0001_0000);
    tick();
    chk("oor_segv", bus.instr_segv, 32'd1);
    chk("oor_wait", bus.wait_instr, 32'd0);
    chk("oor_pc", bus.pc, 32'h0001_0000);
    chk("oor_instr", bus.instruction, 32'h0);
    bus.pc_inc = 1'b1;
    any_req = 0;
    repeat (4) begin
      tick();
      if (bus.mem_req) any_req = 1;
    end
    chk("oor_no_req", 32'(any_req), 32'd0);
    chk("oor_segv_held", bus.instr_segv, 32'd1);
    chk("oor_pc_held", bus.pc, 32'h0001_0000);
    bus.redirect = 1'b1;
    bus.redirect_pc = 32'h0;
    tick();
    bus.redirect = 1'b0;
    got = 0;
    for (int i = 0; i < 20 && !got; i++) begin
      if (!bus.wait_instr) got = 1;
      else tick();
    end
    chk("oor_recover_pc", bus.pc, 32'h0);
    chk("oor_recover_instr", bus.instruction, 32'hA5A5_0000);
    chk("oor_recover_segv", bus.instr_segv, 32'd0);

    // Reset while a request is outstanding and an entry is buffered.
    do_reset(0);
    cur_lat = 3;
    bus.pc_inc = 1'b0;
    found = 0;
    for (int i = 0; i < 40 && !found; i++) begin
      tick();
      if (!bus.wait_instr && bus.mem_req) found = 1;
    end
    chk("mr_busy_seen", 32'(found), 32'd1);
    rst = 1'b1;
    #1;
    check_reset_vals();
    bus.mem_ack = 1'b1;
    bus.mem_rdata = 32'h1234_5678;
    bus.mem_fault = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("mr_no_entry", bus.wait_instr, 32'd1);
    chk("mr_refetch_req", bus.mem_req, 32'd1);
    chk("mr_refetch_addr", bus.mem_addr, 32'h0);
    bus.mem_ack = 1'b0;
    prev_req = bus.mem_req;
    prev_addr = bus.mem_addr;
    prev_ack = 0;
    req_age = 0;
    cur_lat = 0;
    got = 0;
    for (int i = 0; i < 10 && !got; i++) begin
      tick();
      if (!bus.wait_instr) got = 1;
    end
    chk("mr_first_pc", bus.pc, 32'h0);
    chk("mr_first_instr", bus.instruction, 32'hA5A5_0000);

    // Randomized run: consumed stream must follow program order from the last redirect.
    do_reset(0);
    rand_lat = 1;
    fault_mode = 2;
    exp_pc = 32'h0;
    wait_run = 0;
    for (int cyc = 0; cyc < 1500; cyc++) begin
      tick();
      exp_segv = !legal(exp_pc) || faulty(exp_pc);
      if (!bus.wait_instr) begin
        chk("rnd_pc", bus.pc, exp_pc);
        chk("rnd_segv", bus.instr_segv, 32'(exp_segv));
        chk("rnd_instr", bus.instruction, legal(exp_pc) ? word_of(exp_pc) : 32'h0);
        wait_run = 0;
      end else begin
        chk("rnd_empty_segv", bus.instr_segv, 32'd0);
        chk("rnd_empty_instr", bus.instruction, 32'h0);
        wait_run++;
        chk("rnd_stall_bound", 32'(wait_run > 40), 32'd0);
      end
      bus.redirect = 1'b0;
      if ($urandom_range(0, 99) < 8) begin
        bus.redirect = 1'b1;
        bus.redirect_pc = pick_target();
        exp_pc = bus.redirect_pc;
        wait_run = 0;
      end
      bus.pc_inc = ($urandom_range(0, 99) < 70);
      if (!bus.redirect && bus.pc_inc && !bus.wait_instr && !exp_segv) exp_pc = exp_pc + 32'd4;
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
